// File: rtl/input_conditioner.sv
// Two-channel synchroniser + debouncer for the raw A/B lab inputs feeding the (S,T) detector.
// Produces clean levels, one-cycle change strobes and a "nothing pending" flag.
module input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    output logic a,
    output logic b,
    output logic a_edge,
    output logic b_edge,
    output logic settled
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel 0 is A, channel 1 is B.
    logic [1:0]                  w_raw;
    logic [1:0][SYNC_STAGES-1:0] r_sync;
    logic [1:0][CNT_W-1:0]       r_cnt;
    logic [1:0][CNT_W-1:0]       w_cnt_nxt;
    logic [1:0]                  r_lvl;
    logic [1:0]                  w_lvl_nxt;
    logic [1:0]                  r_edge;
    logic [1:0]                  w_upd;
    logic [1:0]                  w_sync;
    logic [1:0]                  w_sync_nxt;
    logic                        r_settled;
    logic                        w_settled_nxt;

    assign w_raw = {raw_b, raw_a};

    always_comb begin
        w_sync     = '0;
        w_sync_nxt = '0;
        w_cnt_nxt  = r_cnt;
        w_upd      = '0;
        w_lvl_nxt  = r_lvl;
        for (int ch = 0; ch < 2; ch++) begin
            w_sync[ch]     = r_sync[ch][SYNC_STAGES-1];
            w_sync_nxt[ch] = r_sync[ch][SYNC_STAGES-2];
            if (w_sync[ch] == r_lvl[ch]) begin
                w_cnt_nxt[ch] = '0;
            end else if (r_cnt[ch] == CNT_LAST) begin
                w_cnt_nxt[ch] = '0;
                w_upd[ch]     = 1'b1;
                w_lvl_nxt[ch] = w_sync[ch];
            end else begin
                w_cnt_nxt[ch] = r_cnt[ch] + CNT_W'(1);
            end
        end
        // Looks one edge ahead so settled drops as soon as a disagreeing sample reaches sync.
        w_settled_nxt = (w_cnt_nxt[0] == '0) && (w_cnt_nxt[1] == '0) &&
                        (w_sync_nxt == w_lvl_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_lvl     <= '0;
            r_edge    <= '0;
            r_settled <= 1'b1;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                r_sync[ch] <= {r_sync[ch][SYNC_STAGES-2:0], w_raw[ch]};
            end
            r_cnt     <= w_cnt_nxt;
            r_lvl     <= w_lvl_nxt;
            r_edge    <= w_upd;
            r_settled <= w_settled_nxt;
        end
    end

    assign a       = r_lvl[0];
    assign b       = r_lvl[1];
    assign a_edge  = r_edge[0];
    assign b_edge  = r_edge[1];
    assign settled = r_settled;

endmodule
